row_output_stage: RTL and testbench
===================================

# row_output_stage

Drain stage at the east edge of a systolic row. It samples the accumulated partial sum leaving the last `block` in the row (`outp_east`, accwidth bits) when that sum is flagged valid. It requantizes the sum to datawidth with round-half-up and saturation, optionally clamps negatives to zero, and buffers the results in a small FIFO with a valid/ready output toward the writeback path. The array cannot stall, so this stage never back-pressures upstream; it drops and flags on overflow.

## Interface
- `datawidth`, 11, operand/result width
- `columns`, 64, PEs per row; sets accumulator growth
- `accwidth`, 2*datawidth+$clog2(columns) (=28), input sum width
- `fifo_depth`, 4, output FIFO entries (power of two, >=2)
- `clk`  in  1  clock; all logic on rising edge
- `rst_overall_n`  in  1  asynchronous, active-low reset
- `rst_vals`  in  1  synchronous clear of pipeline, FIFO and error flag (active high)
- `acc_in`  in  accwidth  signed sum from last PE `outp_east`
- `acc_valid`  in  1  `acc_in` valid this cycle
- `shift_amt`  in  $clog2(accwidth)  right-shift for requantization; sampled with `acc_valid`
- `relu_en`  in  1  clamp negative results to 0; sampled with `acc_valid`
- `out_data`  out  datawidth  signed FIFO head
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head when `out_valid` is also high
- `fifo_full`  out  1  FIFO holds `fifo_depth` entries
- `overflow_err`  out  1  sticky: a result was dropped

## Operation
- S1 (capture): on an edge with `acc_valid`=1, register `acc_in`, `shift_amt`, `relu_en`, and set `s1_vld`. Otherwise clear `s1_vld`.
- S2 (requantize, combinational from S1, written on the next edge):
  - Sign-extend to accwidth+1 bits.
  - If `shift_amt`>0, add 1<<(shift_amt-1).
  - Arithmetic-shift right by `shift_amt`.
  - Saturate to [-2^(datawidth-1), 2^(datawidth-1)-1] = [-1024, 1023].
  - If ReLU is compiled in and the registered `relu_en`=1, force negative results to 0.
- The FIFO write happens when `s1_vld`=1:
  - FIFO not full: the entry is written.
  - FIFO full and no pop in the same cycle: the entry is dropped and `overflow_err` is set until reset or `rst_vals`.
  - FIFO full with a simultaneous pop: both occur and nothing is dropped.
- A pop happens when `out_valid` and `out_ready` are both 1. FIFO order is strict; pointers wrap modulo `fifo_depth`.
- A pop on an empty FIFO is ignored.
- `shift_amt` >= accwidth gives 0 for non-negative sums and -1 for negative sums, before the ReLU clamp.

## Timing
- Reset values, under both `rst_overall_n`=0 (async) and `rst_vals`=1 (sync):
  - `out_data`=0, `out_valid`=0, `fifo_full`=0, `overflow_err`=0.
  - S1 is cleared and the FIFO is emptied.
- `rst_vals` wins over a simultaneous `acc_valid` or pop.
- Latency:
  - `acc_valid` sampled at edge N → entry written at edge N+1.
  - `out_valid`=1 and `out_data` valid after edge N+1 when the FIFO was empty (first-word fall-through).
- Throughput: one result per cycle; back-to-back `acc_valid` is legal.
- `out_data` holds steady while `out_valid`=1 and `out_ready`=0.
- Reset asserted mid-stream discards all in-flight and buffered results; there is no partial output.

## Configuration
- `ROW_OUT_RELU_EN` defined: the ReLU clamp is built and controlled by the sampled `relu_en`.
- `ROW_OUT_RELU_EN` undefined: no clamp logic is built. The `relu_en` port stays in the interface and is ignored; signed saturated results pass through.

## Structure
- Shared package `pe_pkg`:
  - `DATAWIDTH` and `COLUMNS` defaults, and the `ACCWIDTH` derivation.
  - `sat_to_data` function (accwidth+1 → datawidth clamp).
  - `acc_t` and `data_t` signed typedefs, also used by `block`.
- One sub-module, `row_out_fifo`:
  - Parameterized width and depth, synchronous, first-word fall-through.
  - Exposes `full`, `empty`, `push`, `pop`.
  - Async active-low reset plus a synchronous clear.

## Test plan
- `acc_in`=60, `shift_amt`=2, `out_ready`=1 → `out_data`=15, `out_valid` high exactly after edge N+1 for one cycle.
- Rounding at `shift_amt`=2: `acc_in`=6 → 2; `acc_in`=-6 → -1; `acc_in`=5 → 1.
- Saturation, `shift_amt`=0: `acc_in`=2^22 → 1023; `acc_in`=-2^22 → -1024; `acc_in`=2^27-1 with `shift_amt`=27 → 1.
- ReLU: `acc_in`=-40, `shift_amt`=0, `relu_en`=1 → 0 with `ROW_OUT_RELU_EN`, -40 without; `acc_in`=40 → 40 in both builds.
- Overflow: `out_ready`=0, five consecutive inputs 1..5 → `fifo_full`=1, `overflow_err`=1, then draining gives 1,2,3,4. A full FIFO with a simultaneous pop and push drops nothing.
- Reset: two entries buffered and `acc_valid` in flight, then pulse `rst_overall_n` low mid-cycle → outputs 0 immediately, nothing emitted afterwards. Repeat with `rst_vals` and check the sync clear on the next edge.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and widths for the systolic row: PE operand/result widths,
// accumulator width derivation, and the accumulator-to-data saturating clamp.
package pe_pkg;

  localparam int DATAWIDTH = 11;
  localparam int COLUMNS   = 64;
  localparam int ACCWIDTH  = 2 * DATAWIDTH + $clog2(COLUMNS);

  typedef logic signed [ACCWIDTH-1:0]  acc_t;
  typedef logic signed [DATAWIDTH-1:0] data_t;

  localparam logic signed [ACCWIDTH:0] SAT_HI = (ACCWIDTH+1)'((1 << (DATAWIDTH - 1)) - 1);
  localparam logic signed [ACCWIDTH:0] SAT_LO = ~SAT_HI;

  function automatic data_t sat_to_data(input logic signed [ACCWIDTH:0] v);
    data_t r;
    if (v > SAT_HI)      r = {1'b0, {(DATAWIDTH-1){1'b1}}};
    else if (v < SAT_LO) r = {1'b1, {(DATAWIDTH-1){1'b0}}};
    else                 r = v[DATAWIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/row_out_fifo.sv
// First-word fall-through FIFO: rdata shows the head whenever non-empty and
// reads as zero when empty. Push while full is accepted only alongside a pop.
module row_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/row_output_stage.sv
// East-edge drain of a systolic row: capture, round-half-up requantize with
// saturation, optional ReLU (macro ROW_OUT_RELU_EN), FIFO toward writeback.
module row_output_stage
  import pe_pkg::*;
#(
  parameter int datawidth  = DATAWIDTH,
  parameter int columns    = COLUMNS,
  parameter int accwidth   = 2 * datawidth + $clog2(columns),
  parameter int fifo_depth = 4
) (
  input  logic                         clk,
  input  logic                         rst_overall_n,
  input  logic                         rst_vals,
  input  logic signed [accwidth-1:0]   acc_in,
  input  logic                         acc_valid,
  input  logic [$clog2(accwidth)-1:0]  shift_amt,
  input  logic                         relu_en,
  output logic signed [datawidth-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         fifo_full,
  output logic                         overflow_err
);

  localparam int SW = $clog2(accwidth);
  localparam int WW = accwidth + 1;
  localparam logic signed [WW-1:0] Q_HI = WW'((1 << (datawidth - 1)) - 1);
  localparam logic signed [WW-1:0] Q_LO = ~Q_HI;

  logic                        s1_vld_q;
  logic signed [accwidth-1:0]  s1_acc_q;
  logic [SW-1:0]               s1_shift_q;
  logic                        ovf_q, ovf_d;
  logic signed [WW-1:0]        ext, rnd, shifted;
  logic signed [datawidth-1:0] res_sat, res_d;
  logic                        fifo_empty;

  always_ff @(posedge clk or negedge rst_overall_n) begin
    if (!rst_overall_n) begin
      s1_vld_q   <= 1'b0;
      s1_acc_q   <= '0;
      s1_shift_q <= '0;
      ovf_q      <= 1'b0;
    end else if (rst_vals) begin
      s1_vld_q   <= 1'b0;
      s1_acc_q   <= '0;
      s1_shift_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_vld_q <= acc_valid;
      if (acc_valid) begin
        s1_acc_q   <= acc_in;
        s1_shift_q <= shift_amt;
      end
      ovf_q <= ovf_d;
    end
  end

  // Shifts past the accumulator width collapse to the sign (0 or -1).
  always_comb begin
    ext = {s1_acc_q[accwidth-1], s1_acc_q};
    rnd = ext;
    if (s1_shift_q != '0) rnd = ext + (WW'(1) << (s1_shift_q - 1'b1));
    if ({1'b0, s1_shift_q} >= (SW+1)'(accwidth)) shifted = {WW{ext[WW-1]}};
    else                                         shifted = rnd >>> s1_shift_q;
    if (shifted > Q_HI)      res_sat = {1'b0, {(datawidth-1){1'b1}}};
    else if (shifted < Q_LO) res_sat = {1'b1, {(datawidth-1){1'b0}}};
    else                     res_sat = shifted[datawidth-1:0];
  end

`ifdef ROW_OUT_RELU_EN
  logic s1_relu_q;

  always_ff @(posedge clk or negedge rst_overall_n) begin
    if (!rst_overall_n)  s1_relu_q <= 1'b0;
    else if (rst_vals)   s1_relu_q <= 1'b0;
    else if (acc_valid)  s1_relu_q <= relu_en;
  end

  assign res_d = (s1_relu_q && res_sat[datawidth-1]) ? '0 : res_sat;
`else
  logic unused_relu;
  assign unused_relu = relu_en;
  assign res_d       = res_sat;
`endif

  // The array cannot stall: a result arriving at a full FIFO with no pop is lost.
  assign ovf_d        = ovf_q | (s1_vld_q & fifo_full & ~(out_ready & out_valid));
  assign overflow_err = ovf_q;
  assign out_valid    = !fifo_empty;

  row_out_fifo #(
    .WIDTH (datawidth),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_overall_n),
    .clr   (rst_vals),
    .push  (s1_vld_q),
    .pop   (out_ready),
    .wdata (res_d),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_row_output_stage.sv
// Bench for row_output_stage: directed cases plus random traffic against a
// cycle-level queue model with arithmetic requantization.
module tb_row_output_stage;

  localparam int DW    = 11;
  localparam int AW    = 28;
  localparam int SW    = 5;
  localparam int DEPTH = 4;
`ifdef ROW_OUT_RELU_EN
  localparam bit RELU_BUILD = 1'b1;
`else
  localparam bit RELU_BUILD = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_overall_n;
  logic                 rst_vals;
  logic signed [AW-1:0] acc_in;
  logic                 acc_valid;
  logic [SW-1:0]        shift_amt;
  logic                 relu_en;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 fifo_full;
  logic                 overflow_err;

  row_output_stage dut (
    .clk           (clk),
    .rst_overall_n (rst_overall_n),
    .rst_vals      (rst_vals),
    .acc_in        (acc_in),
    .acc_valid     (acc_valid),
    .shift_amt     (shift_amt),
    .relu_en       (relu_en),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .fifo_full     (fifo_full),
    .overflow_err  (overflow_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state: expected FIFO contents and pending capture
  int exp_q[$];
  bit s1_pend = 1'b0;
  int s1_val  = 0;
  bit ovf_m   = 1'b0;

  function automatic int ref_requant(longint acc, int sh, bit relu);
    longint r;
    if (sh >= AW) r = (acc < 0) ? -1 : 0;
    else begin
      r = acc;
      if (sh > 0) r = r + (longint'(1) << (sh - 1));
      r = r >>> sh;
    end
    if (r > 1023)  r = 1023;
    if (r < -1024) r = -1024;
    if (RELU_BUILD && relu && r < 0) r = 0;
    return int'(r);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, ".valid"}, 32'(out_valid), (sz > 0) ? 1 : 0);
    check({tag, ".data"}, 32'($signed(out_data)), (sz > 0) ? exp_q[0] : 0);
    check({tag, ".full"}, 32'(fifo_full), (sz == DEPTH) ? 1 : 0);
    check({tag, ".ovf"}, 32'(overflow_err), int'(ovf_m));
  endtask

  // driver: called at a negedge, advances one clock, checks at the next negedge
  task automatic tick(input bit av, input longint acc, input int sh, input bit relu,
                      input bit rdy, input bit clr, input string tag);
    bit pop;
    acc_valid = av;
    acc_in    = acc[AW-1:0];
    shift_amt = sh[SW-1:0];
    relu_en   = relu;
    out_ready = rdy;
    rst_vals  = clr;
    if (clr) begin
      exp_q.delete();
      s1_pend = 1'b0;
      ovf_m   = 1'b0;
    end else begin
      pop = rdy && (exp_q.size() > 0);
      if (pop) void'(exp_q.pop_front());
      if (s1_pend) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(s1_val);
        else                      ovf_m = 1'b1;
      end
      s1_pend = av;
      if (av) s1_val = ref_requant(acc, sh, relu);
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic single(input string tag, input longint acc, input int sh, input bit relu,
                        input int exp);
    tick(1'b1, acc, sh, relu, 1'b1, 1'b0, {tag, ".cap"});
    check({tag, ".early"}, 32'(out_valid), 0);
    tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, {tag, ".wr"});
    check({tag, ".dir_v"}, 32'(out_valid), 1);
    check({tag, ".dir_d"}, 32'($signed(out_data)), exp);
    tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, {tag, ".pop"});
  endtask

  task automatic fill_three(input string tag);
    tick(1'b1, 100, 0, 1'b0, 1'b0, 1'b0, tag);
    tick(1'b1, 200, 0, 1'b0, 1'b0, 1'b0, tag);
    tick(1'b1, 300, 0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] raw;
    longint        a;
    int            sh;

    rst_overall_n = 1'b0;
    rst_vals      = 1'b0;
    acc_in        = '0;
    acc_valid     = 1'b0;
    shift_amt     = '0;
    relu_en       = 1'b0;
    out_ready     = 1'b0;
    #12;
    check("rst.valid", 32'(out_valid), 0);
    check("rst.data", 32'($signed(out_data)), 0);
    check("rst.full", 32'(fifo_full), 0);
    check("rst.ovf", 32'(overflow_err), 0);
    @(negedge clk);
    rst_overall_n = 1'b1;
    tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, "idle");

    single("lat60", 60, 2, 1'b0, 15);
    single("rnd_p6", 6, 2, 1'b0, 2);
    single("rnd_m6", -6, 2, 1'b0, -1);
    single("rnd_p5", 5, 2, 1'b0, 1);
    single("sat_hi", 64'sd1 << 22, 0, 1'b0, 1023);
    single("sat_lo", -(64'sd1 << 22), 0, 1'b0, -1024);
    single("sat_27", (64'sd1 << 27) - 1, 27, 1'b0, 1);
    single("big_sh_neg", -12345, 31, 1'b0, -1);
    single("relu_neg", -40, 0, 1'b1, RELU_BUILD ? 0 : -40);
    single("relu_pos", 40, 0, 1'b1, 40);

    // overflow: five captures into a four-entry FIFO with no consumer
    for (int i = 1; i <= 5; i++) tick(1'b1, i, 0, 1'b0, 1'b0, 1'b0, "ovf_fill");
    tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "ovf_settle");
    check("ovf.full", 32'(fifo_full), 1);
    check("ovf.err", 32'(overflow_err), 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf.order", 32'($signed(out_data)), i);
      tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, "ovf_drain");
    end
    check("ovf.sticky", 32'(overflow_err), 1);
    tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "clr_ovf");
    check("clr.ovf", 32'(overflow_err), 0);

    // full FIFO with simultaneous pop and push
    for (int i = 10; i <= 14; i++) tick(1'b1, i, 0, 1'b0, 1'b0, 1'b0, "pp_fill");
    tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, "pp_both");
    check("pp.ovf", 32'(overflow_err), 0);
    check("pp.full", 32'(fifo_full), 1);
    check("pp.head", 32'($signed(out_data)), 11);
    for (int i = 0; i < 4; i++) tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, "pp_drain");

    // async reset mid-cycle with buffered and in-flight results
    fill_three("ar_fill");
    acc_valid = 1'b0;
    #2 rst_overall_n = 1'b0;
    #1;
    check("ar.valid", 32'(out_valid), 0);
    check("ar.data", 32'($signed(out_data)), 0);
    check("ar.full", 32'(fifo_full), 0);
    check("ar.ovf", 32'(overflow_err), 0);
    exp_q.delete();
    s1_pend = 1'b0;
    ovf_m   = 1'b0;
    #1 rst_overall_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, "ar_after");

    // synchronous clear beats a concurrent capture and pop
    fill_three("sv_fill");
    tick(1'b1, 999, 0, 1'b0, 1'b1, 1'b1, "sv_clr");
    check("sv.valid", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, "sv_after");

    // random traffic
    for (int n = 0; n < 300; n++) begin
      raw = AW'($urandom);
      case ($urandom_range(0, 3))
        0: a = longint'($urandom_range(0, 4000)) - 2000;
        1: a = longint'($signed(raw)) >>> $urandom_range(4, 16);
        default: a = longint'($signed(raw));
      endcase
      sh = (a > -2000 && a < 2000) ? $urandom_range(0, 4) : $urandom_range(0, 31);
      tick($urandom_range(0, 9) < 7, a, sh, 1'($urandom_range(0, 1)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0, "rand");
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, "final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
